// File: rtl/led_shift_controller.sv
// LED shift-register driver: serialises led_vals MSB-first with a latch pulse
// per frame, and generates a PWM output-enable from brightness.
module led_shift_controller #(
   parameter int WIDTH    = 8,
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [WIDTH-1:0]    led_vals,
   input  logic [PWM_BITS-1:0] brightness,
   output logic                serial_clk,
   output logic                serial_out,
   output logic                latch_enable,
   output logic                output_enable_n
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_CLK_HIGH,
      S_CLK_LOW,
      S_LATCH
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    sr_q, sr_d;
   logic [WIDTH-1:0]    sr_shift;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                sclk_q, sclk_d;
   logic                sout_q, sout_d;
   logic                latch_q, latch_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [PWM_BITS-1:0] bright_q, bright_d;
   logic [PWM_BITS-1:0] bright_eff;
   logic                oe_n_q, oe_n_d;

   assign sr_shift = sr_q << 1;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      sclk_d  = sclk_q;
      sout_d  = sout_q;
      latch_d = latch_q;
      unique case (state_q)
         S_LOAD: begin
            sr_d    = led_vals;
            sout_d  = led_vals[WIDTH-1];
            sclk_d  = 1'b0;
            latch_d = 1'b0;
            cnt_d   = '0;
            state_d = S_CLK_HIGH;
         end
         S_CLK_HIGH: begin
            sclk_d  = 1'b1;
            state_d = (cnt_q == LAST) ? S_LATCH : S_CLK_LOW;
         end
         S_CLK_LOW: begin
            sclk_d  = 1'b0;
            sr_d    = sr_shift;
            sout_d  = sr_shift[WIDTH-1];
            cnt_d   = cnt_q + 1'b1;
            state_d = S_CLK_HIGH;
         end
         S_LATCH: begin
            sclk_d  = 1'b0;
            latch_d = 1'b1;
            state_d = S_LOAD;
         end
         default: state_d = S_LOAD;
      endcase
   end

   // The period-start cycle compares against the live input so a new
   // brightness shows up on the very first edge of its period.
   always_comb begin
      pwm_d      = pwm_q + 1'b1;
      bright_eff = (pwm_q == '0) ? brightness : bright_q;
      bright_d   = bright_eff;
      oe_n_d     = !(pwm_q < bright_eff);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_LOAD;
         sr_q     <= '0;
         cnt_q    <= '0;
         sclk_q   <= 1'b0;
         sout_q   <= 1'b0;
         latch_q  <= 1'b0;
         pwm_q    <= '0;
         bright_q <= '0;
         oe_n_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         sclk_q   <= sclk_d;
         sout_q   <= sout_d;
         latch_q  <= latch_d;
         pwm_q    <= pwm_d;
         bright_q <= bright_d;
         oe_n_q   <= oe_n_d;
      end
   end

   assign serial_clk      = sclk_q;
   assign serial_out      = sout_q;
   assign latch_enable    = latch_q;
   assign output_enable_n = oe_n_q;

endmodule

// File: tb/tb_led_shift_controller.sv
// Self-checking bench for led_shift_controller: vector table, corner
// sequences and randomized inputs against an edge-count reference model.
module tb_led_shift_controller;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] led_vals = 8'h00;
   logic [7:0] brightness = 8'h00;
   logic       serial_clk, serial_out, latch_enable, output_enable_n;

   led_shift_controller #(.WIDTH(8), .PWM_BITS(8)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .led_vals        (led_vals),
      .brightness      (brightness),
      .serial_clk      (serial_clk),
      .serial_out      (serial_out),
      .latch_enable    (latch_enable),
      .output_enable_n (output_enable_n)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Reference model state: edges since reset, frame word, period brightness.
   int         m_n;
   logic [7:0] m_word;
   logic [7:0] m_beff;
   logic       prev_sclk;
   int         rises, latches, lows;
   logic [7:0] bits, bits2;

   typedef struct {
      logic [7:0] led;
      logic [7:0] br;
      logic [7:0] exp_bits;
      int         exp_low;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)",
                  name, act, exp, m_n);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_sclk", {31'd0, serial_clk}, 32'd0);
      chk("rst_sout", {31'd0, serial_out}, 32'd0);
      chk("rst_latch", {31'd0, latch_enable}, 32'd0);
      chk("rst_oe_n", {31'd0, output_enable_n}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk_reset_vals();
      repeat (2) @(negedge clk);
      chk_reset_vals();
      reset_n = 1'b1;
      m_n = 0;
      prev_sclk = 1'b0;
      rises = 0;
      latches = 0;
      lows = 0;
      bits = 8'h00;
      bits2 = 8'h00;
   endtask

   // One rising edge: advance the model, then compare outputs 1 ns later.
   task automatic step();
      int p, q;
      logic e_sclk, e_sout, e_latch, e_oe;
      @(posedge clk);
      m_n++;
      p = (m_n - 1) % 17;
      q = (m_n - 1) % 256;
      if (p == 0) m_word = led_vals;
      if (q == 0) m_beff = brightness;
      e_sclk  = (p % 2) == 1;
      e_latch = (p == 16);
      e_sout  = (p == 16) ? m_word[0] : m_word[7 - p / 2];
      e_oe    = !(q < int'(m_beff));
      #1;
      chk("serial_clk", {31'd0, serial_clk}, {31'd0, e_sclk});
      chk("serial_out", {31'd0, serial_out}, {31'd0, e_sout});
      chk("latch_enable", {31'd0, latch_enable}, {31'd0, e_latch});
      chk("output_enable_n", {31'd0, output_enable_n}, {31'd0, e_oe});
      if (!prev_sclk && serial_clk) begin
         if (m_n <= 17) begin
            bits = {bits[6:0], serial_out};
            rises++;
         end else if (m_n <= 34) begin
            bits2 = {bits2[6:0], serial_out};
         end
      end
      if (latch_enable && m_n <= 17) latches++;
      if (!output_enable_n && m_n <= 256) lows++;
      prev_sclk = serial_clk;
   endtask

   initial begin
      vecs[0] = '{led: 8'hAE, br: 8'h33, exp_bits: 8'hAE, exp_low: 51};
      vecs[1] = '{led: 8'h00, br: 8'h00, exp_bits: 8'h00, exp_low: 0};
      vecs[2] = '{led: 8'hFF, br: 8'hFF, exp_bits: 8'hFF, exp_low: 255};
      vecs[3] = '{led: 8'h5A, br: 8'h80, exp_bits: 8'h5A, exp_low: 128};

      for (int i = 0; i < 4; i++) begin
         led_vals   = vecs[i].led;
         brightness = vecs[i].br;
         do_reset();
         repeat (280) step();
         chk("frame_bits", {24'd0, bits}, {24'd0, vecs[i].exp_bits});
         chk("frame_rises", rises, 8);
         chk("frame_latches", latches, 1);
         chk("pwm_low_count", lows, vecs[i].exp_low);
      end

      // led_vals changes mid-frame: current frame unaffected.
      led_vals   = 8'hAE;
      brightness = 8'h40;
      do_reset();
      repeat (5) step();
      led_vals = 8'h01;
      repeat (29) step();
      chk("midframe_bits1", {24'd0, bits}, 32'h0000_00AE);
      chk("midframe_bits2", {24'd0, bits2}, 32'h0000_0001);

      // Reset asserted mid-frame: immediate reset values, no latch pulse.
      led_vals   = 8'h5A;
      brightness = 8'h10;
      do_reset();
      repeat (8) step();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk_reset_vals();
      chk("abort_no_latch", latches, 0);
      do_reset();
      repeat (40) step();
      chk("restart_bits", {24'd0, bits}, 32'h0000_005A);
      chk("restart_latches", latches, 1);

      // Randomized inputs against the model.
      led_vals   = 8'($urandom);
      brightness = 8'($urandom);
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         step();
         if ($urandom_range(0, 19) == 0) led_vals = 8'($urandom);
         if ($urandom_range(0, 299) == 0) brightness = 8'($urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
